sop_scan_engine: RTL and testbench

SOP_SCAN_ENGINE -- requirements
Module: sop_scan_engine

---
 rtl/sop_pkg.sv | 22 ++
 rtl/sop_term_match.sv | 17 +
 rtl/sop_scan_engine.sv | 166 ++++++++++++++++
 tb/tb_sop_scan_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared types for the sum-of-products scan engine.
//   NIn     : input-vector width the term struct is built for. The engine's N_IN parameter
//             must equal it, because the term fields are sized here.
//   term_t  : one product-term table entry {en, care, val}.
//   state_e : scan FSM states.
package sop_pkg;

  localparam int unsigned NIn = 7;

  typedef struct packed {
    logic           en;
    logic [NIn-1:0] care;  // 1 = bit must equal val, 0 = don't-care
    logic [NIn-1:0] val;
  } term_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/sop_term_match.sv
// Combinational compare of one product term against an input vector.
//   term_i  : table entry {en, care, val}
//   vec_i   : vector under test
//   match_o : 1 when the term is enabled and every cared-for bit agrees
module sop_term_match
  import sop_pkg::*;
(
  input  term_t          term_i,
  input  logic [NIn-1:0] vec_i,
  output logic           match_o
);

  always_comb begin
    match_o = term_i.en && (((vec_i ^ term_i.val) & term_i.care) == '0);
  end

endmodule

// File: rtl/sop_scan_engine.sv
// Sequential sum-of-products evaluator. A request vector is tested against a writable
// table of product terms, one term per cycle in ascending order; the first matching term
// ends the scan.
//   clk, rst                      : clock (rising edge), asynchronous active-high reset
//   cfg_we/addr/care/val/en       : term-table write, accepted only while cfg_ready
//   cfg_ready                     : table writable (FSM idle)
//   in_valid/in_ready/in_vec/in_inv : request handshake; in_inv complements the result
//   out_valid/out_ready           : result handshake
//   out_value                     : out_hit XOR registered in_inv
//   out_hit/out_idx               : match found / index of first match (last index on miss)
//   busy                          : FSM not idle
module sop_scan_engine
  import sop_pkg::*;
#(
  parameter int unsigned N_IN    = NIn,
  parameter int unsigned N_TERMS = 48,
  localparam int unsigned AW     = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [N_IN-1:0] cfg_care,
  input  logic [N_IN-1:0] cfg_val,
  input  logic            cfg_en,
  output logic            cfg_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_value,
  output logic            out_hit,
  output logic [AW-1:0]   out_idx,
  output logic            busy
);

  localparam logic [AW-1:0] LastIdx = AW'(N_TERMS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            inv_q, inv_d;
  logic            out_valid_q, out_valid_d;
  logic            out_hit_q, out_hit_d;
  logic [AW-1:0]   out_idx_q, out_idx_d;

  // Enables are reset; care/val are plain storage since a disabled entry never matches.
  logic [N_TERMS-1:0] en_q, en_d;
  logic [N_IN-1:0]    care_q [N_TERMS];
  logic [N_IN-1:0]    care_d [N_TERMS];
  logic [N_IN-1:0]    val_q  [N_TERMS];
  logic [N_IN-1:0]    val_d  [N_TERMS];

  logic  idle;
  logic  term_hit;
  term_t cur_term;

  assign idle      = (state_q == StIdle);
  assign in_ready  = idle;
  assign cfg_ready = idle;
  assign busy      = !idle;
  assign out_valid = out_valid_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;
  assign out_value = out_hit_q ^ inv_q;

  // Table write; addresses at or beyond N_TERMS decode to nothing and are dropped.
  always_comb begin
    en_d   = en_q;
    care_d = care_q;
    val_d  = val_q;
    if (cfg_we && idle) begin
      for (int i = 0; i < int'(N_TERMS); i++) begin
        if (cfg_addr == AW'(i)) begin
          en_d[i]   = cfg_en;
          care_d[i] = cfg_care;
          val_d[i]  = cfg_val;
        end
      end
    end
  end

  always_comb begin
    cur_term.en   = en_q[idx_q];
    cur_term.care = care_q[idx_q];
    cur_term.val  = val_q[idx_q];
  end

  sop_term_match u_term_match (
    .term_i  (cur_term),
    .vec_i   (vec_q),
    .match_o (term_hit)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    out_hit_d   = out_hit_q;
    out_idx_d   = out_idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          vec_d   = in_vec;
          inv_d   = in_inv;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (term_hit) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_hit_d   = 1'b1;
          out_idx_d   = idx_q;
        end else if (idx_q == LastIdx) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_hit_d   = 1'b0;
          out_idx_d   = LastIdx;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      vec_q       <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
      en_q        <= en_d;
    end
  end

  always_ff @(posedge clk) begin
    care_q <= care_d;
    val_q  <= val_d;
  end

endmodule

// File: tb/tb_sop_scan_engine.sv
module tb_sop_scan_engine;

  localparam int NT = 48;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [6:0] cfg_care;
  logic [6:0] cfg_val;
  logic       cfg_en;
  logic       cfg_ready;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_vec;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  logic       out_value;
  logic       out_hit;
  logic [5:0] out_idx;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       hit;
    logic       value;
    logic [5:0] idx;
    int         lat;
  } exp_t;

  exp_t sb[$];

  logic       m_en   [NT];
  logic [6:0] m_care [NT];
  logic [6:0] m_val  [NT];

  always #5 clk = ~clk;

  sop_scan_engine #(
    .N_IN    (7),
    .N_TERMS (NT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_care  (cfg_care),
    .cfg_val   (cfg_val),
    .cfg_en    (cfg_en),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_hit   (out_hit),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First-match model: hit at term k appears in cycle k+2, a miss in cycle NT+1.
  function automatic exp_t model(input logic [6:0] v, input logic inv);
    exp_t e;
    bit   found = 1'b0;
    e.hit = 1'b0;
    e.idx = 6'(NT - 1);
    e.lat = NT + 1;
    for (int i = 0; i < NT; i++) begin
      if (!found && m_en[i] && (((v ^ m_val[i]) & m_care[i]) == 7'h00)) begin
        found = 1'b1;
        e.hit = 1'b1;
        e.idx = 6'(i);
        e.lat = i + 2;
      end
    end
    e.value = e.hit ^ inv;
    return e;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic hw_reset();
    rst = 1'b1;
    for (int i = 0; i < NT; i++) m_en[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_term(input int addr, input logic [6:0] care, input logic [6:0] val,
                            input logic en);
    cfg_we   = 1'b1;
    cfg_addr = 6'(addr);
    cfg_care = care;
    cfg_val  = val;
    cfg_en   = en;
    if (addr < NT) begin
      m_en[addr]   = en;
      m_care[addr] = care;
      m_val[addr]  = val;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // mid_wr >= 1 attempts a write to entry 5 in that scan cycle (must be dropped).
  task automatic do_req(input logic [6:0] vec, input logic inv, input int stall,
                        input int mid_wr);
    exp_t e;
    int   cyc;
    logic [5:0] idx_h;
    logic       hit_h;
    logic       val_h;
    sb.push_back(model(vec, inv));
    check("in_ready_idle", 32'(in_ready), 32'd1);
    out_ready = (stall == 0);
    in_vec    = vec;
    in_inv    = inv;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    cyc      = 1;
    while (!out_valid && cyc < 200) begin
      if (cyc == mid_wr) begin
        check("cfg_ready_scan", 32'(cfg_ready), 32'd0);
        cfg_we   = 1'b1;
        cfg_addr = 6'd5;
        cfg_care = 7'h7F;
        cfg_val  = vec;
        cfg_en   = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    cfg_we = 1'b0;
    check("out_valid_rise", 32'(out_valid), 32'd1);
    e = sb.pop_front();
    check("latency", 32'(cyc), 32'(e.lat));
    check("out_hit", 32'(out_hit), 32'(e.hit));
    check("out_idx", 32'(out_idx), 32'(e.idx));
    check("out_value", 32'(out_value), 32'(e.value));
    check("busy_done", 32'(busy), 32'd1);
    idx_h = out_idx;
    hit_h = out_hit;
    val_h = out_value;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx", 32'(out_idx), 32'(idx_h));
      check("stall_hit", 32'(out_hit), 32'(hit_h));
      check("stall_value", 32'(out_value), 32'(val_h));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    check("in_ready_hs", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("valid_cleared", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int rises;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_care  = '0;
    cfg_val   = '0;
    cfg_en    = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NT; i++) begin
      m_en[i]   = 1'b0;
      m_care[i] = '0;
      m_val[i]  = '0;
    end

    // Reset state.
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_hit", 32'(out_hit), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_value", 32'(out_value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    hw_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Empty table: full scan, miss.
    do_req(7'h00, 1'b0, 0, -1);

    // Exact-match term 0.
    write_term(0, 7'h7F, 7'h24, 1'b1);
    do_req(7'h24, 1'b0, 0, -1);
    do_req(7'h25, 1'b0, 0, -1);
    do_req(7'h24, 1'b1, 0, -1);

    // Last term with care=0 matches everything.
    hw_reset();
    write_term(47, 7'h00, 7'h00, 1'b1);
    do_req(7'h55, 1'b0, 0, -1);
    do_req(7'h55, 1'b1, 0, -1);

    // First of two matches wins; result held through back-pressure.
    hw_reset();
    write_term(3, 7'h40, 7'h40, 1'b1);
    write_term(9, 7'h7F, 7'h7F, 1'b1);
    do_req(7'h7F, 1'b0, 5, -1);
    do_req(7'h3F, 1'b0, 0, -1);
    do_req(7'h40, 1'b1, 2, -1);

    // Writes during a scan and out-of-range writes are dropped.
    do_req(7'h11, 1'b0, 0, 3);
    do_req(7'h11, 1'b0, 0, -1);
    write_term(50, 7'h00, 7'h00, 1'b1);
    do_req(7'h11, 1'b0, 0, -1);

    // A write in the acceptance cycle is visible to that scan.
    cfg_we   = 1'b1;
    cfg_addr = 6'd1;
    cfg_care = 7'h00;
    cfg_val  = 7'h00;
    cfg_en   = 1'b1;
    m_en[1]   = 1'b1;
    m_care[1] = 7'h00;
    m_val[1]  = 7'h00;
    do_req(7'h11, 1'b0, 0, -1);

    // Reset mid-scan aborts with no result and clears every enable.
    hw_reset();
    write_term(20, 7'h00, 7'h00, 1'b1);
    in_vec   = 7'h0A;
    in_inv   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < NT; i++) m_en[i] = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_cfg_ready", 32'(cfg_ready), 32'd1);
    rises = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("abort_no_result", 32'(rises), 32'd0);
    do_req(7'h0A, 1'b0, 0, -1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
